// File: rtl/score_pkg.sv
// Shared constants, state encoding, font and arithmetic helpers for the
// score bitmap generator.
//   COLS x ROWS  : score bitmap geometry (bit r*COLS+c = row r, col c)
//   FONT         : 3x5 digit glyphs, row-major, MSB = top-left unit
//   sat_score    : clamps a binary score to SCORE_MAX
//   bcd_step     : one shift-add-3 iteration of binary-to-BCD conversion
package score_pkg;
  localparam int SCORE_W    = 10;
  localparam int SCORE_MAX  = 999;
  localparam int COLS       = 16;
  localparam int ROWS       = 48;
  localparam int MAP_W      = COLS * ROWS;
  localparam int GLYPH_W    = 3;
  localparam int GLYPH_H    = 5;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, DRAW, COMMIT} state_t;

  localparam logic [GLYPH_BITS-1:0] FONT [10] = '{
    15'b111_101_101_101_111,  // 0
    15'b010_110_010_010_111,  // 1
    15'b111_001_111_100_111,  // 2
    15'b111_001_111_001_111,  // 3
    15'b101_101_111_001_001,  // 4
    15'b111_100_111_001_111,  // 5
    15'b111_100_111_101_111,  // 6
    15'b111_001_001_001_001,  // 7
    15'b111_101_111_101_111,  // 8
    15'b111_101_111_001_111   // 9
  };

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s;
  endfunction

  // Every nibble >= 5 gets +3, then the whole register shifts in bit_in.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                input logic             bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj[BCD_W-2:0], bit_in};
  endfunction
endpackage

// File: rtl/digit_glyph_rom.sv
// Combinational digit -> 3x5 glyph lookup.
//   digit : BCD digit 0..9 (codes 10..15 give a blank glyph)
//   glyph : 15-bit glyph, row-major, MSB = top-left unit
module digit_glyph_rom
  import score_pkg::*;
(
  input  logic [3:0]            digit,
  output logic [GLYPH_BITS-1:0] glyph
);
  always_comb begin
    glyph = '0;
    if (digit <= 4'd9) glyph = FONT[digit];
  end
endmodule

// File: rtl/score_bitmap_gen.sv
// Renders a 10-bit score as three 3x5 decimal glyphs in a 16x48 bitmap.
// Sequence: IDLE latch -> 10 shift-add-3 cycles -> 3 glyph draw cycles into a
// shadow map -> 1 commit cycle copying shadow to score_map, so the visible map
// only ever changes atomically.
//   clk       : system clock
//   reset     : asynchronous, active-high; blanks the map
//   score     : binary score 0..1023 (values above 999 render as 999)
//   score_map : committed bitmap, bit r*COLS+c = row r, col c
//   busy      : high while a conversion is in flight
//   map_valid : high during the commit cycle; score_map takes the new value
//               at the end of it (15th edge counting the latching edge)
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero glyphs
// (ones digit is always drawn; draw timing is unchanged).
module score_bitmap_gen
  import score_pkg::*;
#(
  parameter int ORIGIN_ROW  = 1,
  parameter int ORIGIN_COL  = 1,
  parameter int DIGIT_PITCH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  output logic [MAP_W-1:0]   score_map,
  output logic               busy,
  output logic               map_valid
);
  state_t                              state, state_n;
  logic [3:0]                          cnt;
  logic [SCORE_W-1:0]                  last_score, shreg, score_sat;
  logic [BCD_W-1:0]                    bcd;
  logic                                drawn, start;
  logic [MAP_W-1:0]                    shadow, draw_vec;
  logic [NUM_DIGITS-1:0][3:0]          dig;
  logic [NUM_DIGITS-1:0][GLYPH_BITS-1:0] glyph;
  logic [NUM_DIGITS-1:0]               draw_en;
  logic [NUM_DIGITS-1:0][MAP_W-1:0]    placed;

  assign score_sat = sat_score(score);
  // drawn=0 forces one render after reset even if the score never changes.
  assign start     = (score_sat != last_score) || !drawn;
  assign busy      = (state != IDLE);

  // Digit 0 = hundreds (top nibble), digit 2 = ones.
  always_comb
    for (int d = 0; d < NUM_DIGITS; d++) dig[d] = bcd[BCD_W-1-4*d -: 4];

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_rom
    digit_glyph_rom u_rom (.digit(dig[d]), .glyph(glyph[d]));
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign draw_en = {1'b1, |{dig[0], dig[1]}, |dig[0]};
`else
  assign draw_en = '1;
`endif

  // Each glyph pre-positioned at its fixed slot; DRAW only selects and ORs.
  always_comb begin
    placed = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      for (int r = 0; r < GLYPH_H; r++)
        for (int c = 0; c < GLYPH_W; c++)
          placed[d][(ORIGIN_ROW+r)*COLS + ORIGIN_COL + d*DIGIT_PITCH + c] =
            glyph[d][GLYPH_BITS-1-(r*GLYPH_W+c)] & draw_en[d];
  end

  always_comb begin
    draw_vec = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (cnt == 4'(d)) draw_vec = placed[d];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n   = state;
    map_valid = 1'b0;
    case (state)
      IDLE:    if (start) state_n = CONVERT;
      CONVERT: if (cnt == 4'(SCORE_W-1)) state_n = DRAW;
      DRAW:    if (cnt == 4'(NUM_DIGITS-1)) state_n = COMMIT;
      COMMIT: begin
        map_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      last_score <= '0;
      shreg      <= '0;
      bcd        <= '0;
      drawn      <= 1'b0;
      shadow     <= '0;
      score_map  <= '0;
    end else begin
      cnt <= (state == IDLE || state_n != state) ? 4'd0 : cnt + 4'd1;
      case (state)
        IDLE: if (start) begin
          last_score <= score_sat;
          shreg      <= score_sat;
          bcd        <= '0;
          shadow     <= '0;
        end
        CONVERT: begin
          bcd   <= bcd_step(bcd, shreg[SCORE_W-1]);
          shreg <= shreg << 1;
        end
        DRAW:    shadow <= shadow | draw_vec;
        COMMIT: begin
          score_map <= shadow;
          drawn     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bitmap_gen.sv
module tb_score_bitmap_gen;
  localparam int MAPW = 768;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [9:0]      score = '0;
  logic [MAPW-1:0] score_map;
  logic            busy, map_valid;

  score_bitmap_gen dut (
    .clk(clk), .reset(reset), .score(score),
    .score_map(score_map), .busy(busy), .map_valid(map_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int              cyc;
    logic [MAPW-1:0] map;
  } exp_t;
  exp_t sbq[$];

  // Reference model state: edge counter, last rendered value, commit edge.
  int cyc = 0;
  int m_last = 0;
  bit m_drawn = 1'b0;
  int m_commit = 0;

  task automatic chk(input string name, input logic [MAPW-1:0] act, input logic [MAPW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] font(input int d);
    case (d)
      0: return 15'b111_101_101_101_111;
      1: return 15'b010_110_010_010_111;
      2: return 15'b111_001_111_100_111;
      3: return 15'b111_001_111_001_111;
      4: return 15'b101_101_111_001_001;
      5: return 15'b111_100_111_001_111;
      6: return 15'b111_100_111_101_111;
      7: return 15'b111_001_001_001_001;
      8: return 15'b111_101_111_101_111;
      default: return 15'b111_101_111_001_111;
    endcase
  endfunction

  // Picture of a saturated score: decimal digits via division, drawn at
  // rows 1..5, columns 1+4*d..3+4*d.
  function automatic logic [MAPW-1:0] golden(input int s);
    logic [MAPW-1:0] m;
    logic [14:0]     g;
    int              dg[3];
    bit              show[3];
    m = '0;
    dg[0] = s / 100; dg[1] = (s / 10) % 10; dg[2] = s % 10;
    show[0] = 1'b1; show[1] = 1'b1; show[2] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    show[0] = (dg[0] != 0);
    show[1] = (dg[0] != 0) || (dg[1] != 0);
`endif
    for (int d = 0; d < 3; d++)
      if (show[d]) begin
        g = font(dg[d]);
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 3; c++)
            if (g[14 - 3*r - c]) m[(1 + r)*16 + 1 + 4*d + c] = 1'b1;
      end
    return m;
  endfunction

  // Model: a new value is accepted on an edge once the previous conversion
  // has committed; the commit lands 14 edges after the accepting edge.
  always @(posedge clk or posedge reset) begin : model
    int s;
    if (reset) begin
      m_last = 0; m_drawn = 1'b0; m_commit = 0;
      sbq.delete();
    end else begin
      cyc++;
      if (cyc > m_commit) begin
        s = (int'(score) > 999) ? 999 : int'(score);
        if (s != m_last || !m_drawn) begin
          m_last = s; m_drawn = 1'b1; m_commit = cyc + 14;
          sbq.push_back('{cyc, golden(s)});
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      chk("busy", MAPW'(busy), MAPW'(m_commit > cyc));
      if (map_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_map_valid", MAPW'(map_valid), '0);
        end else begin
          e = sbq.pop_front();
          chk("map_valid_latency", MAPW'(cyc), MAPW'(e.cyc + 13));
          @(posedge clk); #1;
          chk("score_map", score_map, e.map);
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0 && cyc > m_commit) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", '0, MAPW'(1));
  endtask

  initial begin
    int r;
    #1 reset = 1'b1;
    #2;
    chk("reset_map", score_map, '0);
    chk("reset_busy", MAPW'(busy), '0);
    chk("reset_valid", MAPW'(map_valid), '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_idle();                              // score 0 rendered after reset

    @(negedge clk) score = 10'd123;           // plain change
    wait_idle();

    @(negedge clk) score = 10'd1023;          // saturation
    @(posedge clk);
    repeat (11) @(negedge clk);
    chk("bcd_sat", MAPW'(dut.bcd), MAPW'(12'h999));
    wait_idle();
    @(negedge clk) score = 10'd999;           // same saturated value: no work
    repeat (20) @(negedge clk);

    @(negedge clk) score = 10'd123;           // change during CONVERT
    @(posedge clk);
    repeat (3) @(negedge clk);
    score = 10'd456;
    wait_idle();

    @(negedge clk) score = 10'd7;             // change and return while busy
    @(posedge clk);
    repeat (2) @(negedge clk);
    score = 10'd8;
    @(negedge clk) score = 10'd7;
    wait_idle();

    @(negedge clk) score = 10'd555;           // reset during DRAW
    @(posedge clk);
    repeat (12) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_map", score_map, '0);
    chk("midreset_busy", MAPW'(busy), '0);
    @(negedge clk) reset = 1'b0;
    wait_idle();

    repeat (100) @(negedge clk);              // steady score: no activity

    repeat (60) begin
      @(negedge clk);
      r = $urandom_range(0, 3);
      if (r == 0)      score = 10'($urandom_range(1000, 1023));
      else if (r == 1) score = 10'($urandom_range(0, 20));
      else             score = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    wait_idle();
    repeat (20) @(negedge clk);
    chk("queue_drained", MAPW'(sbq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
